// File: rtl/axi_lite_arbiter_2to1.sv
// rtl/axi_lite_arbiter_2to1.sv - two-master round-robin AXI4-Lite arbiter
// Grants one whole write (AW+W+B) or read (AR+R) at a time and muxes the owner straight through.
module axi_lite_arbiter_2to1 #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  // master 0
  input  logic [ADDR_WIDTH-1:0]     M0_AWADDR,
  input  logic                      M0_AWVALID,
  output logic                      M0_AWREADY,
  input  logic [DATA_WIDTH-1:0]     M0_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   M0_WSTRB,
  input  logic                      M0_WVALID,
  output logic                      M0_WREADY,
  output logic                      M0_BVALID,
  output logic [1:0]                M0_BRESP,
  input  logic                      M0_BREADY,
  input  logic [ADDR_WIDTH-1:0]     M0_ARADDR,
  input  logic                      M0_ARVALID,
  output logic                      M0_ARREADY,
  output logic                      M0_RVALID,
  output logic [DATA_WIDTH-1:0]     M0_RDATA,
  output logic [1:0]                M0_RRESP,
  input  logic                      M0_RREADY,
  // master 1
  input  logic [ADDR_WIDTH-1:0]     M1_AWADDR,
  input  logic                      M1_AWVALID,
  output logic                      M1_AWREADY,
  input  logic [DATA_WIDTH-1:0]     M1_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   M1_WSTRB,
  input  logic                      M1_WVALID,
  output logic                      M1_WREADY,
  output logic                      M1_BVALID,
  output logic [1:0]                M1_BRESP,
  input  logic                      M1_BREADY,
  input  logic [ADDR_WIDTH-1:0]     M1_ARADDR,
  input  logic                      M1_ARVALID,
  output logic                      M1_ARREADY,
  output logic                      M1_RVALID,
  output logic [DATA_WIDTH-1:0]     M1_RDATA,
  output logic [1:0]                M1_RRESP,
  input  logic                      M1_RREADY,
  // slave
  output logic [ADDR_WIDTH-1:0]     S_AWADDR,
  output logic                      S_AWVALID,
  input  logic                      S_AWREADY,
  output logic [DATA_WIDTH-1:0]     S_WDATA,
  output logic [DATA_WIDTH/8-1:0]   S_WSTRB,
  output logic                      S_WVALID,
  input  logic                      S_WREADY,
  input  logic                      S_BVALID,
  input  logic [1:0]                S_BRESP,
  output logic                      S_BREADY,
  output logic [ADDR_WIDTH-1:0]     S_ARADDR,
  output logic                      S_ARVALID,
  input  logic                      S_ARREADY,
  input  logic                      S_RVALID,
  input  logic [DATA_WIDTH-1:0]     S_RDATA,
  input  logic [1:0]                S_RRESP,
  output logic                      S_RREADY,
  output logic [1:0]                GNT,
  output logic                      BUSY
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t     state;
  logic       owner;
  logic       last;
  logic [1:0] gnt;
  logic       busy;

  logic wreq0, wreq1, req0, req1;
  logic pick, pick_wreq;

  assign wreq0 = M0_AWVALID & M0_WVALID;
  assign wreq1 = M1_AWVALID & M1_WVALID;
  assign req0  = wreq0 | M0_ARVALID;
  assign req1  = wreq1 | M1_ARVALID;

  // Under contention the master that was not served last wins; otherwise the sole requester.
  assign pick      = (req0 & req1) ? ~last : req1;
  assign pick_wreq = pick ? wreq1 : wreq0;

  logic [ADDR_WIDTH-1:0]   own_awaddr, own_araddr;
  logic [DATA_WIDTH-1:0]   own_wdata;
  logic [DATA_WIDTH/8-1:0] own_wstrb;
  logic                    own_awvalid, own_wvalid, own_bready, own_arvalid, own_rready;

  assign own_awaddr  = owner ? M1_AWADDR  : M0_AWADDR;
  assign own_awvalid = owner ? M1_AWVALID : M0_AWVALID;
  assign own_wdata   = owner ? M1_WDATA   : M0_WDATA;
  assign own_wstrb   = owner ? M1_WSTRB   : M0_WSTRB;
  assign own_wvalid  = owner ? M1_WVALID  : M0_WVALID;
  assign own_bready  = owner ? M1_BREADY  : M0_BREADY;
  assign own_araddr  = owner ? M1_ARADDR  : M0_ARADDR;
  assign own_arvalid = owner ? M1_ARVALID : M0_ARVALID;
  assign own_rready  = owner ? M1_RREADY  : M0_RREADY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      gnt   <= 2'b00;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            owner <= pick;
            state <= pick_wreq ? WR : RD;
            gnt   <= pick ? 2'b10 : 2'b01;
            busy  <= 1'b1;
          end
        end
        WR: begin
          if (S_BVALID & own_bready) begin
            last  <= owner;
            state <= IDLE;
            gnt   <= 2'b00;
            busy  <= 1'b0;
          end
        end
        RD: begin
          if (S_RVALID & own_rready) begin
            last  <= owner;
            state <= IDLE;
            gnt   <= 2'b00;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign GNT  = gnt;
  assign BUSY = busy;

  // Pure combinational path mux; everything not owned by the active transaction is held at zero.
  always_comb begin
    S_AWADDR   = '0;
    S_AWVALID  = 1'b0;
    S_WDATA    = '0;
    S_WSTRB    = '0;
    S_WVALID   = 1'b0;
    S_BREADY   = 1'b0;
    S_ARADDR   = '0;
    S_ARVALID  = 1'b0;
    S_RREADY   = 1'b0;
    M0_AWREADY = 1'b0;
    M0_WREADY  = 1'b0;
    M0_BVALID  = 1'b0;
    M0_BRESP   = 2'b00;
    M0_ARREADY = 1'b0;
    M0_RVALID  = 1'b0;
    M0_RDATA   = '0;
    M0_RRESP   = 2'b00;
    M1_AWREADY = 1'b0;
    M1_WREADY  = 1'b0;
    M1_BVALID  = 1'b0;
    M1_BRESP   = 2'b00;
    M1_ARREADY = 1'b0;
    M1_RVALID  = 1'b0;
    M1_RDATA   = '0;
    M1_RRESP   = 2'b00;
    case (state)
      WR: begin
        S_AWADDR  = own_awaddr;
        S_AWVALID = own_awvalid;
        S_WDATA   = own_wdata;
        S_WSTRB   = own_wstrb;
        S_WVALID  = own_wvalid;
        S_BREADY  = own_bready;
        if (!owner) begin
          M0_AWREADY = S_AWREADY;
          M0_WREADY  = S_WREADY;
          M0_BVALID  = S_BVALID;
          M0_BRESP   = S_BRESP;
        end else begin
          M1_AWREADY = S_AWREADY;
          M1_WREADY  = S_WREADY;
          M1_BVALID  = S_BVALID;
          M1_BRESP   = S_BRESP;
        end
      end
      RD: begin
        S_ARADDR  = own_araddr;
        S_ARVALID = own_arvalid;
        S_RREADY  = own_rready;
        if (!owner) begin
          M0_ARREADY = S_ARREADY;
          M0_RVALID  = S_RVALID;
          M0_RDATA   = S_RDATA;
          M0_RRESP   = S_RRESP;
        end else begin
          M1_ARREADY = S_ARREADY;
          M1_RVALID  = S_RVALID;
          M1_RDATA   = S_RDATA;
          M1_RRESP   = S_RRESP;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// tb/tb_axi_lite_arbiter_2to1.sv - scoreboard bench for the 2:1 AXI-Lite arbiter
// Includes a 4-register slave model; grants and responses are checked by a decoupled monitor.
module tb_axi_lite_arbiter_2to1;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic ACLK;
  logic ARESET;

  logic [1:0][AW-1:0] m_awaddr, m_araddr;
  logic [1:0][DW-1:0] m_wdata;
  logic [1:0][SW-1:0] m_wstrb;
  logic [1:0]         m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;

  logic [1:0]         awready, wready, arready, bvalid, rvalid;
  logic [1:0][1:0]    bresp, rresp;
  logic [1:0][DW-1:0] rdata;

  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [SW-1:0] s_wstrb;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0] s_bresp, s_rresp;
  logic [1:0] GNT;
  logic BUSY;

  axi_lite_arbiter_2to1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .M0_AWADDR(m_awaddr[0]), .M0_AWVALID(m_awvalid[0]), .M0_AWREADY(awready[0]),
    .M0_WDATA(m_wdata[0]), .M0_WSTRB(m_wstrb[0]), .M0_WVALID(m_wvalid[0]), .M0_WREADY(wready[0]),
    .M0_BVALID(bvalid[0]), .M0_BRESP(bresp[0]), .M0_BREADY(m_bready[0]),
    .M0_ARADDR(m_araddr[0]), .M0_ARVALID(m_arvalid[0]), .M0_ARREADY(arready[0]),
    .M0_RVALID(rvalid[0]), .M0_RDATA(rdata[0]), .M0_RRESP(rresp[0]), .M0_RREADY(m_rready[0]),
    .M1_AWADDR(m_awaddr[1]), .M1_AWVALID(m_awvalid[1]), .M1_AWREADY(awready[1]),
    .M1_WDATA(m_wdata[1]), .M1_WSTRB(m_wstrb[1]), .M1_WVALID(m_wvalid[1]), .M1_WREADY(wready[1]),
    .M1_BVALID(bvalid[1]), .M1_BRESP(bresp[1]), .M1_BREADY(m_bready[1]),
    .M1_ARADDR(m_araddr[1]), .M1_ARVALID(m_arvalid[1]), .M1_ARREADY(arready[1]),
    .M1_RVALID(rvalid[1]), .M1_RDATA(rdata[1]), .M1_RRESP(rresp[1]), .M1_RREADY(m_rready[1]),
    .S_AWADDR(s_awaddr), .S_AWVALID(s_awvalid), .S_AWREADY(s_awready),
    .S_WDATA(s_wdata), .S_WSTRB(s_wstrb), .S_WVALID(s_wvalid), .S_WREADY(s_wready),
    .S_BVALID(s_bvalid), .S_BRESP(s_bresp), .S_BREADY(s_bready),
    .S_ARADDR(s_araddr), .S_ARVALID(s_arvalid), .S_ARREADY(s_arready),
    .S_RVALID(s_rvalid), .S_RDATA(s_rdata), .S_RRESP(s_rresp), .S_RREADY(s_rready),
    .GNT(GNT), .BUSY(BUSY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Slave model: four 32-bit registers, one-cycle ready pulse, response held until accepted.
  logic [DW-1:0] regs [4];
  assign s_bresp = 2'b00;
  assign s_rresp = 2'b00;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (s_awready) begin
        s_awready <= 1'b0;
        s_wready  <= 1'b0;
        if (s_awvalid && s_wvalid) begin
          for (int b = 0; b < SW; b++)
            if (s_wstrb[b]) regs[s_awaddr[3:2]][8*b +: 8] <= s_wdata[8*b +: 8];
          s_bvalid <= 1'b1;
        end
      end else if (s_awvalid && s_wvalid && !s_bvalid) begin
        s_awready <= 1'b1;
        s_wready  <= 1'b1;
      end
      if (s_bvalid && s_bready) s_bvalid <= 1'b0;
      if (s_arready) begin
        s_arready <= 1'b0;
        if (s_arvalid) begin
          s_rdata  <= regs[s_araddr[3:2]];
          s_rvalid <= 1'b1;
        end
      end else if (s_arvalid && !s_rvalid) begin
        s_arready <= 1'b1;
      end
      if (s_rvalid && s_rready) s_rvalid <= 1'b0;
    end
  end

  int vectors;
  int miscompares;

  typedef struct packed { logic rd; logic [DW-1:0] data; } exp_t;
  typedef struct packed { logic [1:0] g; int gap; } gexp_t;
  exp_t  q0[$];
  exp_t  q1[$];
  gexp_t gq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic push_exp(input int m, input logic rd, input logic [DW-1:0] d);
    exp_t e;
    e.rd = rd;
    e.data = d;
    if (m == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic push_gnt(input logic [1:0] g, input int gap);
    gexp_t e;
    e.g = g;
    e.gap = gap;
    gq.push_back(e);
  endtask

  task automatic do_write(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s);
    int n;
    m_awaddr[m] = a;
    m_wdata[m] = d;
    m_wstrb[m] = s;
    m_awvalid[m] = 1'b1;
    m_wvalid[m] = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge ACLK); #1;
      if (awready[m] && wready[m]) break;
    end
    if (n == 200) timeout("aw_handshake");
    @(posedge ACLK); #1;
    m_awvalid[m] = 1'b0;
    m_wvalid[m] = 1'b0;
    for (n = 0; n < 200; n++) begin
      @(negedge ACLK); #1;
      if (bvalid[m] && m_bready[m]) break;
    end
    if (n == 200) timeout("b_handshake");
    @(posedge ACLK); #1;
  endtask

  task automatic do_read(input int m, input logic [AW-1:0] a);
    int n;
    m_araddr[m] = a;
    m_arvalid[m] = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge ACLK); #1;
      if (arready[m]) break;
    end
    if (n == 200) timeout("ar_handshake");
    @(posedge ACLK); #1;
    m_arvalid[m] = 1'b0;
    for (n = 0; n < 200; n++) begin
      @(negedge ACLK); #1;
      if (rvalid[m] && m_rready[m]) break;
    end
    if (n == 200) timeout("r_handshake");
    @(posedge ACLK); #1;
  endtask

  task automatic reset_dut();
    @(negedge ACLK);
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  // Monitor: idle-path invariants, grant order/spacing, and response scoreboard.
  initial begin
    logic [1:0] prev;
    int idle;
    exp_t e;
    gexp_t ge;
    prev = 2'b00;
    idle = 0;
    forever begin
      @(negedge ACLK); #1;
      for (int m = 0; m < 2; m++)
        if (!GNT[m])
          chk($sformatf("m%0d_idle_outputs", m),
              {23'd0, awready[m], wready[m], arready[m], bvalid[m], rvalid[m], bresp[m], rresp[m], rdata[m]},
              64'd0);
      if (GNT == 2'b00)
        chk("s_idle_outputs",
            {15'd0, s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready, s_awaddr, s_araddr, s_wstrb, s_wdata},
            64'd0);
      if (s_awvalid || s_wvalid) chk("s_arvalid_in_wr", {63'd0, s_arvalid}, 64'd0);
      if (GNT != 2'b00 && prev == 2'b00) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", {62'd0, GNT}, 64'd0);
        end else begin
          ge = gq.pop_front();
          chk("grant", {62'd0, GNT}, {62'd0, ge.g});
          if (ge.gap >= 0) chk("idle_gap", 64'(idle), 64'(ge.gap));
        end
        idle = 0;
      end
      if (GNT == 2'b00) idle++;
      for (int m = 0; m < 2; m++) begin
        if ((bvalid[m] && m_bready[m]) || (rvalid[m] && m_rready[m])) begin
          if ((m == 0 ? q0.size() : q1.size()) == 0) begin
            chk($sformatf("m%0d_unexpected_resp", m), 64'd1, 64'd0);
          end else begin
            e = (m == 0) ? q0.pop_front() : q1.pop_front();
            if (bvalid[m]) begin
              chk($sformatf("m%0d_resp_kind", m), 64'd0, {63'd0, e.rd});
              chk($sformatf("m%0d_bresp", m), {62'd0, bresp[m]}, 64'd0);
            end else begin
              chk($sformatf("m%0d_resp_kind", m), 64'd1, {63'd0, e.rd});
              chk($sformatf("m%0d_rdata", m), {32'd0, rdata[m]}, {32'd0, e.data});
              chk($sformatf("m%0d_rresp", m), {62'd0, rresp[m]}, 64'd0);
            end
          end
        end
      end
      prev = GNT;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vectors = 0;
    miscompares = 0;
    m_awaddr = '0; m_araddr = '0; m_wdata = '0; m_wstrb = '0;
    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0;
    m_bready = 2'b11;
    m_rready = 2'b11;
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    #1;
    chk("reset_gnt", {62'd0, GNT}, 64'd0);
    chk("reset_busy", {63'd0, BUSY}, 64'd0);
    @(negedge ACLK);
    ARESET = 1'b0;

    // single master write then read-back
    push_gnt(2'b01, -1);
    push_exp(0, 1'b0, '0);
    do_write(0, 4'h4, 32'hDEADBEEF, 4'hF);
    push_gnt(2'b01, 1);
    push_exp(0, 1'b1, 32'hDEADBEEF);
    do_read(0, 4'h4);

    // simultaneous writes after reset: M0 then M1
    reset_dut();
    push_gnt(2'b01, -1);
    push_gnt(2'b10, 1);
    push_exp(0, 1'b0, '0);
    push_exp(1, 1'b0, '0);
    fork
      do_write(0, 4'h0, 32'h11111111, 4'hF);
      do_write(1, 4'h8, 32'h22222222, 4'hF);
    join

    // continuous contention alternates grants
    push_gnt(2'b01, -1);
    for (int i = 0; i < 5; i++) push_gnt((i % 2 == 0) ? 2'b10 : 2'b01, 1);
    for (int i = 0; i < 3; i++) begin
      push_exp(0, 1'b1, 32'h11111111);
      push_exp(1, 1'b1, 32'h11111111);
    end
    fork
      repeat (3) do_read(0, 4'h0);
      repeat (3) do_read(1, 4'h0);
    join

    // same master write and read together: write first
    push_gnt(2'b10, -1);
    push_gnt(2'b10, 1);
    push_exp(1, 1'b0, '0);
    push_exp(1, 1'b1, 32'h33333333);
    fork
      do_write(1, 4'hC, 32'h33333333, 4'hF);
      do_read(1, 4'hC);
    join

    // held RREADY keeps the grant; pending M1 follows one idle cycle later
    m_rready[0] = 1'b0;
    push_gnt(2'b01, -1);
    push_gnt(2'b10, 1);
    push_exp(0, 1'b1, 32'h22222222);
    push_exp(1, 1'b1, 32'h33333333);
    fork
      do_read(0, 4'h8);
      do_read(1, 4'hC);
      begin
        for (n = 0; n < 200; n++) begin
          @(negedge ACLK); #1;
          if (s_rvalid) break;
        end
        if (n == 200) timeout("s_rvalid_wait");
        repeat (5) begin
          chk("hold_busy", {63'd0, BUSY}, 64'd1);
          chk("hold_gnt", {62'd0, GNT}, 64'd1);
          chk("hold_m0_rvalid", {63'd0, rvalid[0]}, 64'd1);
          @(negedge ACLK);
        end
        m_rready[0] = 1'b1;
      end
    join

    // reset during a write, before the response
    push_gnt(2'b01, -1);
    m_awaddr[0] = 4'h0;
    m_wdata[0] = 32'h55555555;
    m_wstrb[0] = 4'hF;
    m_awvalid[0] = 1'b1;
    m_wvalid[0] = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge ACLK); #1;
      if (GNT == 2'b01) break;
    end
    if (n == 200) timeout("wr_grant_wait");
    chk("pre_reset_bvalid", {63'd0, bvalid[0]}, 64'd0);
    ARESET = 1'b1;
    #1;
    chk("midreset_gnt", {62'd0, GNT}, 64'd0);
    chk("midreset_busy", {63'd0, BUSY}, 64'd0);
    m_awvalid[0] = 1'b0;
    m_wvalid[0] = 1'b0;
    @(negedge ACLK);
    ARESET = 1'b0;
    push_gnt(2'b01, -1);
    push_gnt(2'b10, 1);
    push_exp(0, 1'b0, '0);
    push_exp(1, 1'b0, '0);
    fork
      do_write(0, 4'h0, 32'h66666666, 4'hF);
      do_write(1, 4'h4, 32'h77777777, 4'hF);
    join
    push_gnt(2'b01, 1);
    push_exp(0, 1'b1, 32'h66666666);
    do_read(0, 4'h0);

    repeat (3) @(negedge ACLK);
    #2;
    chk("grant_queue_empty", 64'(gq.size()), 64'd0);
    chk("m0_queue_empty", 64'(q0.size()), 64'd0);
    chk("m1_queue_empty", 64'(q1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter_2to1.md
# axi_lite_arbiter_2to1

Two-master, one-slave AXI4-Lite arbiter placed in front of the 4-register AXI-Lite slave. It lets two bus masters (M0, M1) share the slave. It grants one complete transaction at a time, either a write (AW+W+B) or a read (AR+R), with round-robin fairness between masters. The granted master's channels are muxed straight through to the slave port; the other master is stalled.

## Interface
Parameters:
- ADDR_WIDTH, 4, address width on all ports
- DATA_WIDTH, 32, data width on all ports; strobe width is DATA_WIDTH/8

Ports (x ∈ {0,1}; each Mx_ line is one port per master):
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- Mx_AWADDR / Mx_ARADDR  in  ADDR_WIDTH  master write / read address
- Mx_AWVALID, Mx_WVALID, Mx_ARVALID  in  1  master request valids
- Mx_WDATA  in  DATA_WIDTH  master write data
- Mx_WSTRB  in  DATA_WIDTH/8  master write strobes
- Mx_BREADY, Mx_RREADY  in  1  master response readies
- Mx_AWREADY, Mx_WREADY, Mx_ARREADY  out  1  readies returned to master
- Mx_BVALID  out  1  write response valid to master
- Mx_BRESP  out  2  write response code to master
- Mx_RVALID  out  1  read data valid to master
- Mx_RDATA  out  DATA_WIDTH  read data to master
- Mx_RRESP  out  2  read response code to master
- S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY, S_ARADDR, S_ARVALID, S_RREADY  out  (matching widths)  slave-side request signals
- S_AWREADY, S_WREADY, S_BVALID, S_BRESP, S_ARREADY, S_RVALID, S_RDATA, S_RRESP  in  (matching widths)  slave-side response signals
- GNT  out  2  one-hot grant (bit x = Mx owns slave); 2'b00 when idle
- BUSY  out  1  high while a transaction is granted

## Operation
- State machine with states IDLE, WR, RD. Registers: state, owner (1 bit), last (1 bit, last master served).
- Request per master:
  - wreq_x = Mx_AWVALID & Mx_WVALID. Write is requested only when both are valid, because the slave requires AW and W together.
  - rreq_x = Mx_ARVALID.
  - req_x = wreq_x | rreq_x.
- IDLE arbitration:
  - If both masters request, choose the master ≠ last; otherwise choose the sole requester.
  - For the chosen master, write has priority over read: go to WR if wreq, else RD.
  - Register owner and move to WR or RD.
- WR:
  - Mux owner's AW/W/BREADY to the S_ ports and S_AWREADY/S_WREADY/S_BVALID/S_BRESP back to the owner.
  - S_ARVALID and S_RREADY are 0.
  - On S_BVALID & Mowner_BREADY: last ← owner, state ← IDLE.
- RD:
  - Mux owner's AR/RREADY to the slave and S_ARREADY/S_RVALID/S_RDATA/S_RRESP back to the owner.
  - S_AWVALID, S_WVALID and S_BREADY are 0.
  - On S_RVALID & Mowner_RREADY: last ← owner, state ← IDLE.
- Non-owner, and all masters in IDLE: every Mx_ ready/valid output is 0, Mx_BRESP/Mx_RRESP = 0, Mx_RDATA = 0.
- In IDLE, S_ valids and readies are 0, and S_ address, data and strobe are 0.
- The mux is purely combinational from registered state/owner. There is no data buffering in the arbiter.
- Protocol violations, such as a master dropping VALID before handshake, are not detected. Behaviour then follows the slave.

## Timing
- Reset (ARESET high, async):
  - state = IDLE, owner = 0, last = 1, so M0 wins the first contention.
  - GNT = 0, BUSY = 0, and all outputs are 0.
- Arbitration latency: a request seen in IDLE at edge N makes GNT/BUSY valid and the path open from edge N (registered), i.e. in the cycle after the request is first sampled.
- Release: the response handshake at edge N returns the block to IDLE at N. The earliest next grant is at edge N+1, so there is one idle cycle between transactions.
- A request that appears while BUSY waits; it is arbitrated in the next IDLE cycle.
- Simultaneous write and read requests from the same master: the write is served first. The read is served on a later grant, after the other master if it is also requesting.
- Both masters requesting continuously: grants alternate M0, M1, M0, …
- ARESET mid-transaction: state returns to IDLE immediately. In-flight master responses are dropped; the slave is reset on the same reset tree.

## Test plan
- Reset, then M0 writes 32'hDEADBEEF to addr 4'h4 with WSTRB 4'hF → GNT = 2'b01 for the transaction, M0_BVALID with BRESP = 0. A following M0 read of 4'h4 returns RDATA = 32'hDEADBEEF.
- M0 and M1 both assert a write in the same cycle after reset (M0: 0x11111111 → 0x0, M1: 0x22222222 → 0x8) → M0 is granted first, then M1 after exactly one idle cycle. M1 sees AWREADY = 0 throughout M0's transaction.
- Both masters issue back-to-back reads of 0x0 continuously for 6 transactions → GNT sequence 01, 10, 01, 10, 01, 10.
- M1 asserts a write and a read together → WR granted first, RD on the next grant. S_ARVALID = 0 throughout WR.
- M0 read with M0_RREADY held low for 5 cycles after S_RVALID → BUSY stays 1 and the grant is held. Release occurs on the RREADY cycle, and M1's pending request is granted one cycle later.
- ARESET pulsed while in WR before BVALID → GNT = 0 and BUSY = 0 immediately. The next request after reset is granted to M0 if both request.
